// File: rtl/multi_master_single_slave_arb_pkg.sv
// Shared types and helpers for the crossbar arbiter blocks.
package crossbar_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

    // Index width for grant/pointer registers; never narrower than one bit.
    function automatic int unsigned arb_idx_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/multi_master_single_slave_arb_if.sv
// Single-outstanding request/response bus shared by masters and slaves.
interface slv_interface #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned ARWIDTH = 32
);
    logic               avalid;
    logic               awren;
    logic [WIDTH/8-1:0] awstrb;
    logic [WIDTH-1:0]   awdata;
    logic [ARWIDTH-1:0] addr;
    logic               aready;
    logic               rvalid;
    logic [WIDTH-1:0]   rdata;
    logic               rready;

    modport master (
        output avalid, awren, awstrb, awdata, addr, rready,
        input  aready, rvalid, rdata
    );

    modport slv (
        input  avalid, awren, awstrb, awdata, addr, rready,
        output aready, rvalid, rdata
    );
endinterface

// File: rtl/multi_master_single_slave_arb_rr_pick.sv
// Combinational requester picker: rotating priority from ptr_i, or lowest
// index first when ARB_FIXED_PRIORITY_EN is defined.
module rr_pick
    import crossbar_pkg::*;
#(
    parameter  int unsigned N  = 2,
    localparam int unsigned IW = arb_idx_w(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic          valid_o,
    output logic [IW-1:0] idx_o
);

`ifdef ARB_FIXED_PRIORITY_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr_i;

    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (req_i[N-1-k]) begin
                valid_o = 1'b1;
                idx_o   = IW'(N-1-k);
            end
        end
    end
`else
    int unsigned j;

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        j       = 0;
        for (int unsigned k = 0; k < N; k++) begin
            j = (32'(ptr_i) + (N - 1 - k)) % N;
            if (req_i[j]) begin
                valid_o = 1'b1;
                idx_o   = IW'(j);
            end
        end
    end
`endif

endmodule

// File: rtl/multi_master_single_slave_arb.sv
// Shares one downstream slave port among N_MASTERS requesters, one transaction
// (address + response) per grant. ARB_FIXED_PRIORITY_EN selects fixed priority.
module multi_master_single_slave_arb
    import crossbar_pkg::*;
#(
    parameter int unsigned N_MASTERS = 2,
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned ARWIDTH   = 32
) (
    input logic         clk,
    input logic         rst,
    slv_interface.slv    m [N_MASTERS],
    slv_interface.master s
);

    localparam int unsigned IW = arb_idx_w(N_MASTERS);
    localparam int unsigned SW = WIDTH / 8;

    arb_state_e state_q;
    logic [IW-1:0] gnt_q;
    logic [IW-1:0] rr_ptr;

    logic [N_MASTERS-1:0] m_avalid, m_awren, m_rready;
    logic [ARWIDTH-1:0]   m_addr   [N_MASTERS];
    logic [WIDTH-1:0]     m_awdata [N_MASTERS];
    logic [SW-1:0]        m_awstrb [N_MASTERS];

    logic [N_MASTERS-1:0] m_aready, m_rvalid, resp_sel;
    logic                 s_avalid, s_rready;
    logic                 pick_valid;
    logic [IW-1:0]        pick_idx;
    logic [IW-1:0]        sel;

    if ($bits(s.awdata) != WIDTH || $bits(s.addr) != ARWIDTH) begin : g_s_width_err
        $error("slv_interface s: WIDTH/ARWIDTH differ from arbiter parameters");
    end

    for (genvar i = 0; i < N_MASTERS; i++) begin : g_m
        if ($bits(m[i].awdata) != WIDTH || $bits(m[i].addr) != ARWIDTH) begin : g_width_err
            $error("slv_interface m[%0d]: WIDTH/ARWIDTH differ from arbiter parameters", i);
        end
        assign m_avalid[i] = m[i].avalid;
        assign m_awren[i]  = m[i].awren;
        assign m_rready[i] = m[i].rready;
        assign m_addr[i]   = m[i].addr;
        assign m_awdata[i] = m[i].awdata;
        assign m_awstrb[i] = m[i].awstrb;
        assign m[i].aready = m_aready[i];
        assign m[i].rvalid = m_rvalid[i];
        assign m[i].rdata  = resp_sel[i] ? s.rdata : '0;
    end

    rr_pick #(.N(N_MASTERS)) u_pick (
        .req_i   (m_avalid),
        .ptr_i   (rr_ptr),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

`ifdef ARB_FIXED_PRIORITY_EN
    assign rr_ptr = '0;
`else
    logic [IW-1:0] rr_q, rr_d;
    assign rr_ptr = rr_q;
    assign rr_d   = (gnt_q == IW'(N_MASTERS - 1)) ? '0 : gnt_q + 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            gnt_q   <= '0;
`ifndef ARB_FIXED_PRIORITY_EN
            rr_q    <= '0;
`endif
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (pick_valid) begin
                        gnt_q   <= pick_idx;
                        state_q <= s.aready ? ARB_RESP : ARB_ADDR;
                    end
                end
                ARB_ADDR: begin
                    if (s.aready && m_avalid[gnt_q]) state_q <= ARB_RESP;
                end
                ARB_RESP: begin
                    if (s.rvalid && m_rready[gnt_q]) begin
                        state_q <= ARB_IDLE;
`ifndef ARB_FIXED_PRIORITY_EN
                        rr_q    <= rr_d;
`endif
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    // In IDLE the live pick drives the bus; afterwards the grant is locked.
    assign sel = (state_q == ARB_IDLE) ? pick_idx : gnt_q;

    always_comb begin
        s_avalid = 1'b0;
        s_rready = 1'b0;
        m_aready = '0;
        m_rvalid = '0;
        resp_sel = '0;
        if (!rst) begin
            case (state_q)
                ARB_IDLE: begin
                    s_avalid           = pick_valid;
                    m_aready[pick_idx] = pick_valid & s.aready;
                end
                ARB_ADDR: begin
                    s_avalid        = m_avalid[gnt_q];
                    m_aready[gnt_q] = m_avalid[gnt_q] & s.aready;
                end
                ARB_RESP: begin
                    s_rready        = m_rready[gnt_q];
                    m_rvalid[gnt_q] = s.rvalid;
                    resp_sel[gnt_q] = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign s.avalid = s_avalid;
    assign s.rready = s_rready;
    assign s.addr   = m_addr[sel];
    assign s.awren  = m_awren[sel];
    assign s.awstrb = m_awstrb[sel];
    assign s.awdata = m_awdata[sel];

endmodule

// File: tb/tb_multi_master_single_slave_arb.sv
// Randomized scoreboard bench for multi_master_single_slave_arb (3 masters).
module tb_multi_master_single_slave_arb;
    import crossbar_pkg::*;

    localparam int unsigned NM = 3;
    localparam logic [31:0] K  = 32'hDEADBFEF;  // slave returns addr ^ K
`ifdef ARB_FIXED_PRIORITY_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NM-1:0] mv, mw, mr, ordy, orv;
    logic [31:0]   ma [NM];
    logic [31:0]   md [NM];
    logic [3:0]    ms [NM];
    logic [31:0]   ord [NM];
    logic          s_ardy, s_rv;
    logic [31:0]   s_rd;

    slv_interface #(.WIDTH(32), .ARWIDTH(32)) m_if [NM] ();
    slv_interface #(.WIDTH(32), .ARWIDTH(32)) s_if ();

    for (genvar g = 0; g < NM; g++) begin : g_m
        assign m_if[g].avalid = mv[g];
        assign m_if[g].awren  = mw[g];
        assign m_if[g].awstrb = ms[g];
        assign m_if[g].awdata = md[g];
        assign m_if[g].addr   = ma[g];
        assign m_if[g].rready = mr[g];
        assign ordy[g] = m_if[g].aready;
        assign orv[g]  = m_if[g].rvalid;
        assign ord[g]  = m_if[g].rdata;
    end
    assign s_if.aready = s_ardy;
    assign s_if.rvalid = s_rv;
    assign s_if.rdata  = s_rd;

    multi_master_single_slave_arb #(.N_MASTERS(NM), .WIDTH(32), .ARWIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .m   (m_if),
        .s   (s_if)
    );

    int unsigned nchk = 0, npass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    typedef struct packed {
        logic [31:0] mst;
        logic [31:0] data;
    } exp_t;
    exp_t expq[$];

    // Reference model: phase 0 = free, 1 = grant locked awaiting accept, 2 = awaiting response.
    int unsigned phase = 0, ptr = 0, w = 0;
    bit chk_rst = 1'b0;
    logic [NM-1:0] en;
    int unsigned req_pct, ardy_pct, rready_pct, lat_min, lat_max;
    bit s_wait;
    int unsigned s_cnt;
    logic [31:0] s_val;
    int unsigned nresp = 0;
    logic [31:0] last_rd = '0;

    function automatic int unsigned pick(input logic [NM-1:0] r, input int unsigned p);
        for (int unsigned k = 0; k < NM; k++)
            if (r[(p + k) % NM]) return (p + k) % NM;
        return 0;
    endfunction

    task automatic step();
        logic [NM-1:0] acc, exp_ardy, exp_rv;
        logic s_acc, s_rhs, exp_sav, exp_srr, hs;
        logic [31:0] cap;
        int unsigned ew;
        exp_t e;
        acc = '0; s_acc = 1'b0; s_rhs = 1'b0; cap = '0;
        @(negedge clk);
        if (rst) begin
            chk("rst_s_avalid", 64'(s_if.avalid), 64'(0));
            chk("rst_s_rready", 64'(s_if.rready), 64'(0));
            chk("rst_m_aready", 64'(ordy), 64'(0));
            chk("rst_m_rvalid", 64'(orv), 64'(0));
            for (int unsigned i = 0; i < NM; i++) chk("rst_m_rdata", 64'(ord[i]), 64'(0));
            phase = 0; ptr = 0;
            expq.delete();
        end else begin
            if (chk_rst) begin
                chk("reset_state", 64'(dut.state_q), 64'(ARB_IDLE));
                chk("reset_gnt", 64'(dut.gnt_q), 64'(0));
                chk_rst = 1'b0;
            end
`ifndef ARB_FIXED_PRIORITY_EN
            chk("rr_q", 64'(dut.rr_q), 64'(ptr));
`endif
            exp_ardy = '0; exp_rv = '0; exp_sav = 1'b0; exp_srr = 1'b0; hs = 1'b0;
            ew = w;
            case (phase)
                0: if (|mv) begin
                    ew = pick(mv, FIXED ? 0 : ptr);
                    exp_sav = 1'b1;
                    exp_ardy[ew] = s_ardy;
                    hs = s_ardy;
                end
                1: begin
                    exp_sav = mv[w];
                    exp_ardy[w] = s_ardy & mv[w];
                    hs = s_ardy & mv[w];
                end
                default: begin
                    exp_srr = mr[w];
                    exp_rv[w] = s_rv;
                end
            endcase
            chk("s_avalid", 64'(s_if.avalid), 64'(exp_sav));
            chk("m_aready", 64'(ordy), 64'(exp_ardy));
            chk("s_rready", 64'(s_if.rready), 64'(exp_srr));
            chk("m_rvalid", 64'(orv), 64'(exp_rv));
            for (int unsigned i = 0; i < NM; i++) begin
                if (phase == 2 && i == w) chk("m_rdata_fwd", 64'(ord[i]), 64'(s_rd));
                else chk("m_rdata_zero", 64'(ord[i]), 64'(0));
            end
            if (hs) begin
                chk("s_addr", 64'(s_if.addr), 64'(ma[ew]));
                chk("s_awdata", 64'(s_if.awdata), 64'(md[ew]));
                chk("s_awren", 64'(s_if.awren), 64'(mw[ew]));
                chk("s_awstrb", 64'(s_if.awstrb), 64'(ms[ew]));
                e.mst = ew;
                e.data = ma[ew] ^ K;
                expq.push_back(e);
            end
            case (phase)
                0: if (|mv) begin w = ew; phase = s_ardy ? 2 : 1; end
                1: if (hs) phase = 2;
                default: if (s_rv && mr[w]) begin
                    phase = 0;
                    ptr = FIXED ? 0 : (w + 1) % NM;
                end
            endcase
            acc   = mv & ordy;
            s_acc = s_if.avalid & s_ardy;
            cap   = s_if.addr ^ K;
            s_rhs = s_rv & s_if.rready;
        end
        @(posedge clk); #1;
        for (int unsigned i = 0; i < NM; i++) begin
            if (acc[i]) mv[i] = 1'b0;
            if (!mv[i] && en[i] && $urandom_range(99) < req_pct) begin
                mv[i] = 1'b1;
                ma[i] = $urandom() & 32'hFFFF_FFFC;
                md[i] = $urandom();
                mw[i] = 1'($urandom_range(1));
                ms[i] = 4'($urandom_range(15));
            end
            mr[i] = ($urandom_range(99) < rready_pct);
        end
        s_ardy = ($urandom_range(99) < ardy_pct);
        if (s_rhs) begin s_rv = 1'b0; s_rd = '0; end
        if (s_acc) begin s_wait = 1'b1; s_cnt = $urandom_range(lat_max, lat_min); s_val = cap; end
        if (s_wait) begin
            if (s_cnt == 0) begin s_rv = 1'b1; s_rd = s_val; s_wait = 1'b0; end
            else s_cnt--;
        end
    endtask

    // Response monitor: pops the scoreboard on every master-side response handshake.
    always @(negedge clk) begin
        logic hs;
        int unsigned hi;
        exp_t e;
        hs = 1'b0; hi = 0;
        if (!rst) begin
            for (int unsigned i = 0; i < NM; i++)
                if (!hs && orv[i] && mr[i]) begin hs = 1'b1; hi = i; end
            if (hs) begin
                if (expq.size() == 0) chk("resp_unexpected", 64'(1), 64'(0));
                else begin
                    e = expq.pop_front();
                    chk("resp_master", 64'(hi), 64'(e.mst));
                    chk("resp_rdata", 64'(ord[hi]), 64'(e.data));
                    nresp++;
                    last_rd = ord[hi];
                end
            end
        end
    end

    initial begin
        mv = '0; mw = '0; mr = '0; en = '0;
        for (int unsigned i = 0; i < NM; i++) begin ma[i] = '0; md[i] = '0; ms[i] = '0; end
        s_ardy = 1'b0; s_rv = 1'b0; s_rd = '0; s_wait = 1'b0; s_cnt = 0; s_val = '0;
        req_pct = 0; ardy_pct = 0; rready_pct = 0; lat_min = 0; lat_max = 0;

        repeat (3) step();
        rst = 1'b0;
        chk_rst = 1'b1;

        // Single request from master 1, accepted immediately, response three cycles later.
        mv[1] = 1'b1; ma[1] = 32'h100; md[1] = 32'h1234; mw[1] = 1'b0; ms[1] = 4'hF;
        mr = '1; s_ardy = 1'b1; ardy_pct = 100; rready_pct = 100; lat_min = 2; lat_max = 2;
        repeat (8) step();
        chk("single_resp_cnt", 64'(nresp), 64'(1));
        chk("single_rdata", 64'(last_rd), 64'(32'hDEADBEEF));

        // Continuous contention from all masters.
        en = '1; req_pct = 100; lat_min = 0; lat_max = 1;
        repeat (40) step();

        // Mixed random traffic with address stalls and response backpressure.
        req_pct = 40; ardy_pct = 50; rready_pct = 60; lat_min = 0; lat_max = 3;
        repeat (1500) step();

        // Reset while a response is pending.
        for (int n = 0; n < 300 && phase != 2; n++) step();
        chk("reach_resp", 64'(phase == 2), 64'(1));
        rst = 1'b1;
        step();
        rst = 1'b0; s_rv = 1'b0; s_rd = '0; s_wait = 1'b0;
        chk_rst = 1'b1;
        repeat (500) step();

        en = '0; ardy_pct = 100; rready_pct = 100;
        for (int n = 0; n < 200 && !(expq.size() == 0 && mv == '0 && phase == 0 && !s_rv && !s_wait); n++)
            step();
        chk("drain_queue", 64'(expq.size()), 64'(0));

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule

// File: doc/multi_master_single_slave_arb.md
# multi_master_single_slave_arb

Arbiter that shares one slave port (slv_interface: avalid/awren/awstrb/awdata/addr/aready/rvalid/rdata/rready) between N requesting masters, e.g. instruction fetch and load/store ports in front of the single_master_multi_slave decoder.
- Grants one master at a time and holds the grant for exactly one transaction: address accept plus response.
- Routes the response back to the granted master only.
- Default policy is round-robin. A compile-time option selects fixed priority.

## Interface
Parameters:
- N_MASTERS, 2, number of requesters (≥2)
- WIDTH, 32, data width; must equal WIDTH of every connected interface (elaboration $error otherwise)
- ARWIDTH, 32, address width; same check as WIDTH

Ports:
- clk  input  1  single clock, all state on posedge
- rst  input  1  reset, synchronous, active-high
- m[N_MASTERS]  slv_interface.slv  —  requester ports; arbiter acts as their slave
- s  slv_interface.master  —  shared downstream port; arbiter acts as its master

## Operation
- State: arb_state_e {ARB_IDLE, ARB_ADDR, ARB_RESP}, registered grant index gnt_q, round-robin pointer rr_q.
- ARB_IDLE:
  - Winner = first i with m[i].avalid, searching from rr_q upward and wrapping modulo N_MASTERS.
  - Winner's addr/awren/awstrb/awdata drive s combinationally; s.avalid = any m.avalid; m[winner].aready = s.aready.
  - s.aready=1 → ARB_RESP, gnt_q←winner.
  - s.aready=0 with a request → ARB_ADDR, gnt_q←winner (grant locked).
  - No request → stay.
- ARB_ADDR:
  - Only m[gnt_q] is forwarded; s.avalid = m[gnt_q].avalid. No re-arbitration.
  - On s.aready & s.avalid → ARB_RESP.
  - m[gnt_q].avalid dropping is a master protocol violation; it is not checked in RTL.
- ARB_RESP:
  - s.avalid=0; every m[i].aready=0.
  - m[gnt_q].rvalid/rdata = s.rvalid/s.rdata; s.rready = m[gnt_q].rready.
  - On s.rvalid & s.rready → ARB_IDLE, rr_q←(gnt_q+1) mod N_MASTERS.
- Non-granted masters always see aready=0, rvalid=0, rdata=0.
- Writes (awren=1) still complete through the response phase. The slave returns rvalid for writes, as the decoder does.

## Timing
- Reset values: state=ARB_IDLE, gnt_q=0, rr_q=0.
- While rst=1, all outputs are forced 0: s.avalid, s.rready, all m.aready, m.rvalid, m.rdata.
- Address latency: 0 cycles. A request present in ARB_IDLE with s.aready=1 is accepted in the same cycle.
- Response path: combinational, 0 cycles.
- Turnaround: one ARB_IDLE cycle between a response handshake and the next address accept, so back-to-back throughput is 1 transaction per (2 + slave latency) cycles.
- Only one outstanding transaction. New requests are held off (aready=0) in ARB_ADDR and ARB_RESP.
- Simultaneous requests: resolved in ARB_IDLE by the pointer, losers wait.
- The pointer wrap from N_MASTERS-1 goes to 0.
- Reset mid-transaction: the transaction is abandoned and the FSM returns to ARB_IDLE. The downstream slave must share rst.
- rr_q changes only on the response handshake, never on address accept.

## Configuration
- ARB_FIXED_PRIORITY_EN defined: the winner is always the lowest-index requesting master. rr_q is not implemented; its logic is removed.
- ARB_FIXED_PRIORITY_EN undefined: round-robin as described in Operation.
- All FSM and timing behaviour is otherwise identical.

## Structure
- crossbar_pkg holds:
  - typedef enum logic[1:0] arb_state_e.
  - localparam function arb_idx_w(n) = max(1, $clog2(n)), used for gnt_q/rr_q width.
- Sub-module rr_pick:
  - Combinational.
  - Inputs: req[N], ptr.
  - Outputs: valid, idx.
  - Fixed priority when the macro is set (ptr ignored).
- The FSM, muxing and width checks live in multi_master_single_slave_arb.

## Test plan
- Single request: m[1] addr=0x100, s.aready=1 at cycle 0 → accepted cycle 0. Slave rvalid with rdata=0xDEADBEEF at cycle 3 → m[1].rvalid cycle 3, m[0].rvalid stays 0, FSM in ARB_IDLE cycle 4.
- Contention, round-robin: m[0] and m[1] request continuously with slave latency 1 → grant order 0,1,0,1; rr_q=1 after first response.
- Stall in address: s.aready=0 for 4 cycles while m[0] is granted, m[1] raises avalid meanwhile → grant stays 0 until accept; m[1].aready=0 throughout.
- Response backpressure: s.rvalid=1, m[0].rready=0 for 3 cycles → s.rready=0, FSM holds ARB_RESP, rdata stable. Release → handshake, then ARB_IDLE.
- Reset mid-ARB_RESP: rst=1 for 1 cycle → next cycle state=ARB_IDLE, rr_q=0, all outputs 0.
- ARB_FIXED_PRIORITY_EN build: N_MASTERS=3, all request continuously → master 0 wins every arbitration; masters 1 and 2 never granted.
